// File: rtl/inst_encoder.sv
// RV32I instruction encoder for the instruction-memory load path, with a 2-entry output buffer.
// Optional immediate range/alignment checking is enabled by defining INST_ENC_RANGE_CHECK_EN.
module inst_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_fmt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              out_err
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);

  logic [31:0]       enc_inst;
  logic              enc_err;
  logic [31:0]       slot0_inst, slot1_inst;
  logic              slot0_err, slot1_err;
  logic [1:0]        count;
  logic [ADDR_W-1:0] addr;
  logic              push, pop;
  logic              unused_imm;

  // JAL's top immediate bits only matter to the optional range check.
  assign unused_imm = ^in_imm[31:21];

  always_comb begin
    enc_inst = NOP_INST;
    enc_err  = 1'b1;
    case (in_fmt)
      3'd0: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0010011};
`ifdef INST_ENC_RANGE_CHECK_EN
        enc_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
`else
        enc_err  = 1'b0;
`endif
      end
      3'd1: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'b0000011};
`ifdef INST_ENC_RANGE_CHECK_EN
        enc_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
`else
        enc_err  = 1'b0;
`endif
      end
      3'd2: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'b0100011};
`ifdef INST_ENC_RANGE_CHECK_EN
        enc_err  = !((&in_imm[31:11]) || !(|in_imm[31:11]));
`else
        enc_err  = 1'b0;
`endif
      end
      3'd3: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], 7'b1100011};
`ifdef INST_ENC_RANGE_CHECK_EN
        enc_err  = !((&in_imm[31:12]) || !(|in_imm[31:12])) || in_imm[0];
`else
        enc_err  = 1'b0;
`endif
      end
      3'd4: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'b1101111};
`ifdef INST_ENC_RANGE_CHECK_EN
        enc_err  = !((&in_imm[31:20]) || !(|in_imm[31:20])) || in_imm[0];
`else
        enc_err  = 1'b0;
`endif
      end
      default: begin
        enc_inst = NOP_INST;
        enc_err  = 1'b1;
      end
    endcase
  end

  // in_ready depends only on occupancy and clear, never on out_ready.
  assign in_ready  = (count != 2'd2) && !clear;
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign out_inst = out_valid ? slot0_inst : 32'h0;
  assign out_err  = out_valid && slot0_err;
  assign out_addr = addr;

  // Slot 0 is always the head; a push+pop can only happen at occupancy 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot0_inst <= 32'h0;
      slot0_err  <= 1'b0;
      slot1_inst <= 32'h0;
      slot1_err  <= 1'b0;
      count      <= 2'd0;
      addr       <= BASE;
    end else if (clear) begin
      count <= 2'd0;
      addr  <= BASE;
    end else begin
      if (pop) begin
        addr <= addr + ADDR_W'(1);
      end
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            slot0_inst <= enc_inst;
            slot0_err  <= enc_err;
          end else begin
            slot1_inst <= enc_inst;
            slot1_err  <= enc_err;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0_inst <= slot1_inst;
          slot0_err  <= slot1_err;
          count      <= count - 2'd1;
        end
        2'b11: begin
          slot0_inst <= enc_inst;
          slot0_err  <= enc_err;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: table of encode vectors fed through a queue scoreboard, plus
// hand-written backpressure, clear and reset sequences. Uses ADDR_W=2 to exercise wrap.
module tb_inst_encoder;

  localparam int AW = 2;
`ifdef INST_ENC_RANGE_CHECK_EN
  localparam logic RC = 1'b1;
`else
  localparam logic RC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_fmt = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [31:0]   in_imm = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_inst;
  logic [AW-1:0] out_addr;
  logic          out_err;

  always #5 clk = ~clk;

  inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_addr(out_addr), .out_err(out_err)
  );

  typedef struct {
    logic [31:0] inst;
    logic        err;
  } exp_t;

  typedef struct {
    logic [2:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] imm;
    logic [31:0] inst;
    logic        err;
  } vec_t;

  vec_t          vecs[14];
  exp_t          sbq[$];
  exp_t          cur_exp;
  logic [AW-1:0] exp_addr = '0;
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every cycle against the model, then apply the model's handshakes.
  always @(negedge clk) begin
    if (rst_n) begin
      automatic logic m_in_ready = (sbq.size() < 2) && !clear;
      automatic logic m_push = in_valid && m_in_ready;
      automatic logic m_pop = (sbq.size() != 0) && out_ready && !clear;
      checkOutput("in_ready", {31'b0, in_ready}, {31'b0, m_in_ready});
      checkOutput("out_valid", {31'b0, out_valid}, {31'b0, sbq.size() != 0});
      checkOutput("out_addr", {30'b0, out_addr}, {30'b0, exp_addr});
      if (sbq.size() != 0) begin
        checkOutput("out_inst", out_inst, sbq[0].inst);
        checkOutput("out_err", {31'b0, out_err}, {31'b0, sbq[0].err});
      end
      if (clear) begin
        sbq.delete();
        exp_addr = '0;
      end else begin
        if (m_pop) begin
          void'(sbq.pop_front());
          exp_addr = exp_addr + 1'b1;
        end
        if (m_push) sbq.push_back(cur_exp);
      end
    end
  end

  task automatic driveFields(input vec_t v);
    in_fmt       = v.fmt;
    in_rd        = v.rd;
    in_rs1       = v.rs1;
    in_rs2       = v.rs2;
    in_funct3    = v.f3;
    in_imm       = v.imm;
    cur_exp.inst = v.inst;
    cur_exp.err  = v.err;
    in_valid     = 1'b1;
  endtask

  task automatic waitAccept();
    bit ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 20 cycles expected 1");
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    driveFields(v);
    waitAccept();
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    exp_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] held_inst;
    vecs[0]  = '{3'd0, 5'd1,  5'd2,  5'd9,  3'd0, 32'hFFFF_FFFF, 32'hFFF1_0093, 1'b0};
    vecs[1]  = '{3'd3, 5'd17, 5'd1,  5'd2,  3'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
    vecs[2]  = '{3'd4, 5'd1,  5'd31, 5'd31, 3'd7, 32'h0000_0800, 32'h0010_00EF, 1'b0};
    vecs[3]  = '{3'd1, 5'd5,  5'd6,  5'd0,  3'd2, 32'h0000_0008, 32'h0083_2283, 1'b0};
    vecs[4]  = '{3'd2, 5'd9,  5'd2,  5'd7,  3'd2, 32'h0000_0014, 32'h0071_2A23, 1'b0};
    vecs[5]  = '{3'd6, 5'd1,  5'd2,  5'd3,  3'd0, 32'h0000_0000, 32'h0000_0013, 1'b1};
    vecs[6]  = '{3'd2, 5'd0,  5'd0,  5'd0,  3'd0, 32'h0000_0800, 32'h8000_0023, RC};
    vecs[7]  = '{3'd3, 5'd0,  5'd0,  5'd0,  3'd0, 32'h0000_0003, 32'h0000_0163, RC};
    vecs[8]  = '{3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFF_FFFE, 32'hFFFF_F06F, 1'b0};
    vecs[9]  = '{3'd0, 5'd3,  5'd4,  5'd0,  3'd7, 32'h0000_07FF, 32'h7FF2_7193, 1'b0};
    vecs[10] = '{3'd0, 5'd0,  5'd0,  5'd0,  3'd0, 32'hFFFF_F800, 32'h8000_0013, 1'b0};
    vecs[11] = '{3'd0, 5'd0,  5'd0,  5'd0,  3'd0, 32'h0000_0800, 32'h8000_0013, RC};
    vecs[12] = '{3'd4, 5'd0,  5'd0,  5'd0,  3'd0, 32'h0000_0001, 32'h0000_006F, RC};
    vecs[13] = '{3'd7, 5'd4,  5'd4,  5'd4,  3'd4, 32'h1234_5678, 32'h0000_0013, 1'b1};

    // Reset state while rst_n is held low.
    #12;
    checkOutput("rst_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("rst_out_inst", out_inst, 32'd0);
    checkOutput("rst_out_err", {31'b0, out_err}, 32'd0);
    checkOutput("rst_out_addr", {30'b0, out_addr}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Streaming table with the consumer always ready; addresses wrap modulo 4.
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) applyStimulus(vecs[i]);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: two words fill the buffer, the third waits for a pop.
    doReset();
    out_ready = 1'b0;
    applyStimulus(vecs[0]);
    applyStimulus(vecs[1]);
    driveFields(vecs[2]);
    @(negedge clk);
    held_inst = out_inst;
    repeat (3) begin
      @(negedge clk);
      checkOutput("full_in_ready", {31'b0, in_ready}, 32'd0);
      checkOutput("hold_inst", out_inst, 32'hFFF1_0093);
      checkOutput("hold_addr", {30'b0, out_addr}, 32'd0);
    end
    checkOutput("hold_stable", out_inst, held_inst);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    waitAccept();
    repeat (4) @(posedge clk);
    #1;

    // Clear with two words buffered and a pending input.
    out_ready = 1'b0;
    applyStimulus(vecs[3]);
    applyStimulus(vecs[4]);
    driveFields(vecs[8]);
    clear = 1'b1;
    @(negedge clk);
    checkOutput("clear_in_ready", {31'b0, in_ready}, 32'd0);
    @(posedge clk);
    #1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("clear_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("clear_out_addr", {30'b0, out_addr}, 32'd0);

    // Reset with a word buffered discards it.
    @(posedge clk);
    #1;
    applyStimulus(vecs[9]);
    doReset();
    @(negedge clk);
    checkOutput("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(vecs[10]);
    repeat (3) @(posedge clk);
    #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_encoder.md
# inst_encoder

Instruction encoder that packs decoded fields (format, register indices, funct3, full-width immediate) into 32-bit RV32I instruction words. It is the inverse of the decode-stage immediate extraction and covers the same formats: I-ALU, load, store, branch, and JAL. It sits on the instruction-memory load path, fed by the test loader or host interface. It tags each word with its target word address and delivers words through a 2-entry valid/ready output buffer.

## Interface
- `ADDR_W`, default 10: width of the word-address counter.
- `BASE_ADDR`, default 0: word address loaded on reset and on `clear`.

- `clk` input 1: clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `clear` input 1: synchronous flush; empties the buffer and reloads the address counter.
- `in_valid` input 1: an input field set is presented.
- `in_ready` output 1: the encoder can accept a field set this cycle.
- `in_fmt` input 3: 0=I (0010011), 1=LD (0000011), 2=ST (0100011), 3=BEQ (1100011), 4=JAL (1101111); 5–7 are illegal.
- `in_rd`, `in_rs1`, `in_rs2` input 5 each: register indices.
- `in_funct3` input 3: funct3 field; ignored for JAL.
- `in_imm` input 32: signed byte-offset immediate.
- `out_valid` output 1: the buffer head is valid.
- `out_ready` input 1: the consumer accepts the head this cycle.
- `out_inst` output 32: encoded word at the buffer head.
- `out_addr` output ADDR_W: word address of the buffer head.
- `out_err` output 1: the head word failed the range, alignment, or format check.

## Operation
- Encoding by format:
  - I/LD: {imm[11:0], rs1, funct3, rd, op}.
  - ST: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - BEQ: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, op}.
  - Fields a format does not use are ignored.
- The encoding is combinational from the input fields. The word is written into the buffer on an input handshake (`in_valid && in_ready`).
- Buffer: 2-entry FIFO holding {inst, err}, with occupancy 0..2.
  - `in_ready = (occupancy < 2) && !clear`.
  - `in_ready` has no combinational dependence on `out_ready`.
- `out_valid = (occupancy != 0)`. The head is popped on an output handshake (`out_valid && out_ready`).
- Address counter: `out_addr` is the address of the head word.
  - It increments by 1 on each output handshake.
  - It wraps modulo 2^ADDR_W with no flag.
- Illegal `in_fmt` (5–7): the stored word is 0x00000013 (NOP), and err=1 regardless of configuration.

## Timing
- Reset (async assert, sync deassert by the environment) sets:
  - occupancy 0, `out_valid`=0;
  - `out_inst`=0, `out_err`=0;
  - `out_addr`=BASE_ADDR;
  - `in_ready`=1 from the first cycle after `rst_n` rises.
- Latency: a word accepted at edge N is at the head (`out_valid`=1) after edge N if the buffer was empty. Otherwise it is presented after the older word pops.
- Head hold: while `out_valid && !out_ready`, `out_inst`, `out_addr`, and `out_err` are held stable.
- Simultaneous push and pop:
  - occupancy 1: stays 1, and the new word becomes the head after the edge;
  - occupancy 2: no push is possible because `in_ready`=0; after the pop, `in_ready`=1 in the next cycle.
- `clear` has priority over both handshakes. At that edge: occupancy becomes 0, `out_addr`=BASE_ADDR, and nothing is pushed (`in_ready` is 0 during `clear`).
- Reset mid-transfer discards buffered words; they are not replayed.

## Configuration
- `INST_ENC_RANGE_CHECK_EN` defined: err=1 when `in_imm` does not fit the format. The word is still encoded from the truncated bits. Fit rules:
  - I/LD/ST: bits [31:11] must be identical.
  - BEQ: bits [31:12] must be identical and imm[0]=0.
  - JAL: bits [31:20] must be identical and imm[0]=0.
- Not defined: no range or alignment checks; immediates are silently truncated, and err is set only for illegal `in_fmt`.

## Test plan
- Reset, then one I word (rd=1, rs1=2, funct3=0, imm=-1) with `out_ready`=1 → `out_inst`=0xFFF10093, `out_addr`=0, err=0, `out_valid` high for one cycle.
- BEQ (rs1=1, rs2=2, funct3=0, imm=-4) then JAL (rd=1, imm=2048) → 0xFE208EE3 at addr 0, then 0x001000EF at addr 1.
- With `out_ready`=0, push 3 words → `in_ready` drops after the 2nd push, the 3rd is held by the source, the head stays stable; raising `out_ready` drains all 3 in order at addrs 0, 1, 2.
- With the macro defined: ST imm=2048 → err=1; BEQ imm=3 → err=1; `in_fmt`=6 → `out_inst`=0x00000013, err=1 (err=1 for the illegal format in both builds).
- ADDR_W=2: 5 words → `out_addr` sequence 0, 1, 2, 3, 0.
- Assert `clear` with 2 words buffered and `in_valid`=1 → next cycle `out_valid`=0, `out_addr`=BASE_ADDR, no word accepted.
